// File: rtl/storage_arb_pkg.sv
// Shared types and defaults for the Matrix_storage arbiter.
// Owner ids double as requester bit indices.
package storage_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned N_REQ      = 3;

    typedef enum logic [1:0] {
        OWN_INPUT = 2'd0,
        OWN_DISP  = 2'd1,
        OWN_CALC  = 2'd2,
        OWN_NONE  = 2'd3
    } owner_e;

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_e;

    function automatic logic [N_REQ-1:0] owner_onehot(input owner_e owner);
        logic [N_REQ-1:0] oh;
        oh = '0;
        unique case (owner)
            OWN_INPUT: oh = 3'b001;
            OWN_DISP:  oh = 3'b010;
            OWN_CALC:  oh = 3'b100;
            default:   oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/arb_pick3.sv
// Combinational winner select among three requesters.
// STORAGE_ARB_RR_EN selects round-robin; otherwise fixed priority calc > input > display.
module arb_pick3
    import storage_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  owner_e           last_owner_i,
    output owner_e           winner_o
);

`ifdef STORAGE_ARB_RR_EN
    logic [1:0] start;

    always_comb begin
        start    = 2'd0;
        winner_o = OWN_NONE;
        unique case (last_owner_i)
            OWN_INPUT: start = 2'd1;
            OWN_DISP:  start = 2'd2;
            default:   start = 2'd0;
        endcase
        // Walk the search order backwards so the earliest match is written last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(start) + i) % N_REQ;
            if (req_i[idx]) begin
                winner_o = owner_e'(2'(idx));
            end
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner_i;

    always_comb begin
        winner_o = OWN_NONE;
        if (req_i[OWN_CALC]) begin
            winner_o = OWN_CALC;
        end else if (req_i[OWN_INPUT]) begin
            winner_o = OWN_INPUT;
        end else if (req_i[OWN_DISP]) begin
            winner_o = OWN_DISP;
        end
    end
`endif

endmodule

// File: rtl/storage_arbiter.sv
// Req/gnt arbiter sharing the single-port Matrix_storage between input, display and calc.
// Define STORAGE_ARB_RR_EN for round-robin selection instead of fixed priority.
module storage_arbiter
    import storage_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_lock,
    input  logic [N_REQ-1:0]          i_we,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_wdata,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [N_REQ-1:0]          o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_busy,
    output logic                      o_mem_we,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata
);

    localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CntW-1:0]   burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;

    owner_e           winner, pick_last;
    logic [N_REQ-1:0] own_oh;
    logic [1:0]       own_idx;
    logic             own_req, own_lock, own_we, others_req;

    assign own_oh     = owner_onehot(owner_q);
    assign own_idx    = (owner_q == OWN_NONE) ? 2'd0 : 2'(owner_q);
    assign own_req    = |(i_req & own_oh);
    assign own_lock   = |(i_lock & own_oh);
    assign own_we     = |(i_we & own_oh);
    assign others_req = |(i_req & ~own_oh);

    arb_pick3 u_pick (
        .req_i        (i_req),
        .last_owner_i (pick_last),
        .winner_o     (winner)
    );

`ifdef STORAGE_ARB_RR_EN
    // Pointer holds the id the next search starts from.
    logic [1:0] rr_ptr_q, rr_ptr_d;

    assign pick_last = (rr_ptr_q == 2'd0) ? OWN_CALC : owner_e'(rr_ptr_q - 2'd1);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == S_IDLE && winner != OWN_NONE) begin
            rr_ptr_d = (winner == OWN_CALC) ? 2'd0 : 2'(winner) + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign pick_last = OWN_NONE;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rvalid_d    = '0;
        o_mem_we    = 1'b0;
        o_mem_addr  = addr_q;
        o_mem_wdata = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                burst_d = '0;
                if (winner != OWN_NONE) begin
                    state_d = S_OWN;
                    owner_d = winner;
                end
            end
            S_OWN: begin
                if (!own_req) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                    burst_d = '0;
                end else begin
                    o_mem_we    = own_we;
                    o_mem_addr  = i_addr[ADDR_W*int'(own_idx) +: ADDR_W];
                    o_mem_wdata = i_wdata[DATA_W*int'(own_idx) +: DATA_W];
                    addr_d      = o_mem_addr;
                    wdata_d     = o_mem_wdata;
                    rvalid_d    = own_we ? '0 : own_oh;
                    if (!own_lock && others_req && burst_q == BurstLast) begin
                        state_d = S_IDLE;
                        owner_d = OWN_NONE;
                        burst_d = '0;
                    end else if (!own_lock && burst_q != BurstLast) begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_NONE;
            burst_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign o_gnt    = (state_q == S_OWN) ? own_oh : '0;
    assign o_busy   = (state_q == S_OWN);
    assign o_rvalid = rvalid_q;
    assign o_rdata  = i_mem_rdata;

endmodule
